// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// reset_sequencer: asynchronous reset synchroniser feeding an ordered release
// of CHANNELS reset outputs. Outputs assert at once on rst. They release
// one at a time after a hold period, with a fixed gap between channels.
// A synchronous software request restarts the release sequence without
// going through the synchroniser.
module reset_sequencer #(
    parameter int STAGES   = 2,
    parameter int CHANNELS = 3,
    parameter int HOLD     = 16,
    parameter int GAP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_rst,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready
);
    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0] CNT_SAT   = '1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(CHANNELS - 1);
    localparam logic [IW-1:0] IDX_FIRST = IW'(1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("reset_sequencer: STAGES must be >= 2");
        end
        if (CHANNELS < 1) begin : g_bad_channels
            $error("reset_sequencer: CHANNELS must be >= 1");
        end
        if (HOLD < 1) begin : g_bad_hold
            $error("reset_sequencer: HOLD must be >= 1");
        end
        if (GAP < 1) begin : g_bad_gap
            $error("reset_sequencer: GAP must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    logic [STAGES-1:0]   sync_q;
    logic                rst_sync;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CHANNELS-1:0] out_d;
    logic                rdy_d;

    // Synchroniser: preset on rst, zeros shift in so release is clk-aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[STAGES-2:0], 1'b0};
    end

    assign rst_sync = sync_q[STAGES-1];

    // Saturating increment; the counter is only compared against HOLD-1/GAP-1
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    // FSM, counter, channel index and the registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= IDX_FIRST;
            rst_out <= '1;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_out <= out_d;
            ready   <= rdy_d;
        end
    end

    // Next-state: sw_rst overrides everything, otherwise walk the sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = rst_out;
        rdy_d   = ready;
        if (sw_rst) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = IDX_FIRST;
            out_d   = '1;
            rdy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (!rst_sync) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        out_d[0] = 1'b0;
                        cnt_d    = '0;
                        if (CHANNELS == 1) begin
                            state_d = ST_DONE;
                            rdy_d   = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_FIRST;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        // Decode the index so no out-of-range select exists
                        for (int k = 1; k < CHANNELS; k++) begin
                            if (idx_q == IW'(k)) out_d[k] = 1'b0;
                        end
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                            rdy_d   = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
// Bench for reset_sequencer: a release-time model checked every cycle on the
// default instance, plus literal edge-by-edge expectations on both instances.
module tb_reset_sequencer;
    localparam int P_ST   = 2;
    localparam int P_CH   = 3;
    localparam int P_HOLD = 16;
    localparam int P_GAP  = 4;
    localparam int BIG    = 32'h3fff_ffff;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       sw_rst = 1'b0;
    logic [2:0] rst_out;
    logic       ready;
    logic [0:0] rst_out2;
    logic       ready2;

    int m_tot = 0, m_bad = 0, d_tot = 0, d_bad = 0;

    // model state: edge count, pending rst restart, release edge of channel 0
    int ge = 0;
    int t_rst = BIG;
    int t_sw = 0;
    bit pend = 1'b1;
    int n_rst_rise = 0;
    int n_seen = 0;

    reset_sequencer #(.STAGES(P_ST), .CHANNELS(P_CH), .HOLD(P_HOLD), .GAP(P_GAP)) dut (
        .clk(clk), .rst(rst), .sw_rst(sw_rst), .rst_out(rst_out), .ready(ready)
    );

    reset_sequencer #(.STAGES(3), .CHANNELS(1), .HOLD(1), .GAP(7)) dut2 (
        .clk(clk), .rst(rst), .sw_rst(sw_rst), .rst_out(rst_out2), .ready(ready2)
    );

    always #5 clk = ~clk;

    always @(posedge rst) n_rst_rise++;

    // Release-time model: channel k drops at t0 + k*GAP, where t0 is the later
    // of the rst-derived and sw_rst-derived release edges.
    always @(posedge clk) begin
        ge++;
        if (n_rst_rise != n_seen) begin
            n_seen = n_rst_rise;
            pend   = 1'b1;
            t_sw   = 0;
        end
        if (rst) begin
            pend = 1'b1;
            t_sw = 0;
        end else begin
            if (pend) begin
                pend  = 1'b0;
                t_rst = ge + P_ST + P_HOLD;
            end
            if (sw_rst) t_sw = ge + 1 + P_HOLD;
        end
    end

    logic [2:0] e_out;
    logic       e_rdy;
    bit         held;
    int         rel;

    always @(negedge clk) begin
        held = pend || rst || (n_rst_rise != n_seen);
        rel  = (t_rst > t_sw) ? t_rst : t_sw;
        for (int k = 0; k < P_CH; k++) e_out[k] = held || (ge < rel + k * P_GAP);
        e_rdy = !held && (ge >= rel + (P_CH - 1) * P_GAP);
        m_tot++;
        if ({rst_out, ready} !== {e_out, e_rdy}) begin
            m_bad++;
            $display("FAIL model edge=%0d rst_out=%b ready=%b want rst_out=%b ready=%b",
                     ge, rst_out, ready, e_out, e_rdy);
        end
    end

    task automatic at_edge(input int e);
        while (ge < e) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        d_tot++;
        if (got !== exp) begin
            d_bad++;
            $display("FAIL %s got=%b want=%b", nm, got, exp);
        end
    endtask

    int b, c;

    initial begin
        // reset state
        at_edge(2);
        chk("reset_main", {rst_out, ready}, 4'b1110);
        chk("reset_d2", {2'b00, rst_out2, ready2}, 4'b0010);

        // release from power-on reset
        at_edge(5);
        b = ge;
        #2 rst = 1'b0;
        at_edge(b + 4);  chk("d2_e4", {2'b00, rst_out2, ready2}, 4'b0010);
        at_edge(b + 5);  chk("d2_e5", {2'b00, rst_out2, ready2}, 4'b0001);
        at_edge(b + 18); chk("e18", {rst_out, ready}, 4'b1110);
        at_edge(b + 19); chk("e19", {rst_out, ready}, 4'b1100);
        at_edge(b + 23); chk("e23", {rst_out, ready}, 4'b1000);
        at_edge(b + 27); chk("e27", {rst_out, ready}, 4'b0001);

        // software reset on edges 40..42
        at_edge(b + 39);
        #2 sw_rst = 1'b1;
        at_edge(b + 40); chk("sw_e40", {rst_out, ready}, 4'b1110);
        at_edge(b + 42);
        #2 sw_rst = 1'b0;
        at_edge(b + 43); chk("sw_d2_e43", {2'b00, rst_out2, ready2}, 4'b0010);
        at_edge(b + 44); chk("sw_d2_e44", {2'b00, rst_out2, ready2}, 4'b0001);
        at_edge(b + 58); chk("sw_e58", {rst_out, ready}, 4'b1110);
        at_edge(b + 59); chk("sw_e59", {rst_out, ready}, 4'b1100);
        at_edge(b + 66); chk("sw_e66", {rst_out, ready}, 4'b1000);
        at_edge(b + 67); chk("sw_e67", {rst_out, ready}, 4'b0001);

        // 1 ns rst glitch while DONE
        at_edge(b + 80);
        #2 rst = 1'b1;
        #0.5;
        chk("glitch_async", {rst_out, ready}, 4'b1110);
        chk("glitch_async_d2", {2'b00, rst_out2, ready2}, 4'b0010);
        #0.5 rst = 1'b0;
        at_edge(b + 85); chk("glitch_d2_e5", {2'b00, rst_out2, ready2}, 4'b0001);
        at_edge(b + 98); chk("glitch_e18", {rst_out, ready}, 4'b1110);
        at_edge(b + 99); chk("glitch_e19", {rst_out, ready}, 4'b1100);

        // rst reasserted mid-RELEASE, just after edge 21 of that sequence
        at_edge(b + 100);
        @(posedge clk);
        #1 rst = 1'b1;
        #0.5;
        chk("midrel_async", {rst_out, ready}, 4'b1110);
        at_edge(b + 104);
        c = ge;
        #2 rst = 1'b0;
        at_edge(c + 4);  chk("midrel_d2_e4", {2'b00, rst_out2, ready2}, 4'b0010);
        at_edge(c + 5);  chk("midrel_d2_e5", {2'b00, rst_out2, ready2}, 4'b0001);
        at_edge(c + 18); chk("midrel_e18", {rst_out, ready}, 4'b1110);
        at_edge(c + 19); chk("midrel_e19", {rst_out, ready}, 4'b1100);
        at_edge(c + 23); chk("midrel_e23", {rst_out, ready}, 4'b1000);
        at_edge(c + 27); chk("midrel_e27", {rst_out, ready}, 4'b0001);

        // sw_rst held across rst deassertion; last high at edge b+150
        at_edge(b + 140);
        #2 begin rst = 1'b1; sw_rst = 1'b1; end
        at_edge(b + 143);
        #2 rst = 1'b0;
        at_edge(b + 150);
        chk("swhold_e150", {rst_out, ready}, 4'b1110);
        #2 sw_rst = 1'b0;
        at_edge(b + 151); chk("swhold_d2_151", {2'b00, rst_out2, ready2}, 4'b0010);
        at_edge(b + 152); chk("swhold_d2_152", {2'b00, rst_out2, ready2}, 4'b0001);
        at_edge(b + 166); chk("swhold_e166", {rst_out, ready}, 4'b1110);
        at_edge(b + 167); chk("swhold_e167", {rst_out, ready}, 4'b1100);
        at_edge(b + 175); chk("swhold_e175", {rst_out, ready}, 4'b0001);

        at_edge(b + 185);
        $display("test done: total=%0d bad=%0d", m_tot + d_tot, m_bad + d_bad);
        $finish;
    end

endmodule
